// File: rtl/frame_extrema_tracker_pkg.sv
// -----------------------------------------------------------------------------
// extrema_pkg
// Shared types for the frame extrema tracker:
//   - W / CW      : sample width and width of the saturating count/index fields
//   - state_t     : accumulator state (ST_FIRST = no frame open, ST_ACCUM = open)
//   - result_t    : one frame result record (max, min, max_idx, max_ties, cnt)
//   - sat_inc()   : increment that sticks at 2^CW-1 instead of wrapping
// -----------------------------------------------------------------------------
package extrema_pkg;

    localparam int W  = 16;
    localparam int CW = 8;

    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic [W-1:0]  max;
        logic [W-1:0]  min;
        logic [CW-1:0] max_idx;
        logic [CW-1:0] max_ties;
        logic [CW-1:0] cnt;
    } result_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_extrema_tracker_if.sv
// -----------------------------------------------------------------------------
// frame_extrema_tracker_if
// Bundles the sample input stream and the result record output stream.
//   Input stream : in_valid, in_ready, in_data[W], in_last
//   Output stream: out_valid, out_ready, out_max[W], out_min[W],
//                  out_max_idx[CW], out_max_ties[CW], out_cnt[CW]
// Modports: slave  = the tracker itself, master = the surrounding logic/bench.
// -----------------------------------------------------------------------------
interface frame_extrema_tracker_if;
    import extrema_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_max;
    logic [W-1:0]  out_min;
    logic [CW-1:0] out_max_idx;
    logic [CW-1:0] out_max_ties;
    logic [CW-1:0] out_cnt;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_min,
               out_max_idx, out_max_ties, out_cnt
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_min,
               out_max_idx, out_max_ties, out_cnt
    );

endinterface

// File: rtl/frame_extrema_tracker_mag_cmp16.sv
// -----------------------------------------------------------------------------
// mag_cmp16
// Combinational unsigned magnitude compare of two W-bit operands.
//   a_i, b_i : operands (unsigned)
//   lt_o     : a < b
//   eq_o     : a == b
//   gt_o     : a > b
// Exactly one output is high for any operand pair.
// -----------------------------------------------------------------------------
module mag_cmp16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o,
    output logic         eq_o,
    output logic         gt_o
);

    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
    // Derived from the other two so the three outputs are one-hot by construction.
    assign gt_o = !lt_o && !eq_o;

endmodule

// File: rtl/frame_extrema_tracker.sv
// -----------------------------------------------------------------------------
// frame_extrema_tracker
// Streams framed unsigned samples and, at the end of each frame, emits one
// record: max, min, index of the first max, count of samples equal to the max,
// and sample count. Count/index fields saturate at 2^CW-1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (drops open frame and pending record)
//   bus   : frame_extrema_tracker_if.slave (sample stream in, record stream out)
// -----------------------------------------------------------------------------
module frame_extrema_tracker
    import extrema_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    frame_extrema_tracker_if.slave  bus
);

    state_t  state_q;
    result_t acc_q;
    result_t acc_d;
    result_t res_q;
    logic    out_valid_q;

    logic    in_ready;
    logic    accept;

    logic    max_lt, max_eq, max_gt;
    logic    min_lt, min_eq, min_gt;

    mag_cmp16 #(.W(W)) u_cmp_max (
        .a_i  (bus.in_data),
        .b_i  (acc_q.max),
        .lt_o (max_lt),
        .eq_o (max_eq),
        .gt_o (max_gt)
    );

    mag_cmp16 #(.W(W)) u_cmp_min (
        .a_i  (bus.in_data),
        .b_i  (acc_q.min),
        .lt_o (min_lt),
        .eq_o (min_eq),
        .gt_o (min_gt)
    );

    // A pending record blocks input unless it is being consumed this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Accumulator value including the presented sample; all terms use the
    // pre-update register contents.
    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_FIRST) begin
            acc_d.max      = bus.in_data;
            acc_d.min      = bus.in_data;
            acc_d.max_idx  = '0;
            acc_d.max_ties = CW'(1);
            acc_d.cnt      = CW'(1);
        end else begin
            // Strict gt keeps max_idx on the first occurrence. cnt_q is itself
            // saturated, so max_idx saturates with it.
            if (max_gt) begin
                acc_d.max      = bus.in_data;
                acc_d.max_idx  = acc_q.cnt;
                acc_d.max_ties = CW'(1);
            end else if (max_eq) begin
                acc_d.max_ties = sat_inc(acc_q.max_ties);
            end
            if (min_lt) begin
                acc_d.min = bus.in_data;
            end
            acc_d.cnt = sat_inc(acc_q.cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FIRST;
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                acc_q   <= acc_d;
                state_q <= bus.in_last ? ST_FIRST : ST_ACCUM;
            end
            // Loading a new record takes priority over clearing a consumed one,
            // which gives zero-bubble back-to-back records.
            if (accept && bus.in_last) begin
                res_q       <= acc_d;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_max      = res_q.max;
    assign bus.out_min      = res_q.min;
    assign bus.out_max_idx  = res_q.max_idx;
    assign bus.out_max_ties = res_q.max_ties;
    assign bus.out_cnt      = res_q.cnt;

    // Each comparator must report exactly one relation.
    a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({max_lt, max_eq, max_gt}) && $onehot({min_lt, min_eq, min_gt}));

endmodule

// File: tb/tb_frame_extrema_tracker.sv
// -----------------------------------------------------------------------------
// tb_frame_extrema_tracker
// Directed and randomised frames against a queue-based reference model, plus
// literal expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_frame_extrema_tracker;
    import extrema_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_extrema_tracker_if bus();

    frame_extrema_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int mx;
        int mn;
        int idx;
        int ties;
        int cnt;
    } rec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_popped = 0;
    rec_t exp_q[$];
    int   cur_q[$];
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Record of a completed frame, straight from the definitions.
    function automatic rec_t model(input int s[$]);
        rec_t r;
        int   first;
        r.mx = s[0];
        r.mn = s[0];
        foreach (s[i]) begin
            if (s[i] > r.mx) r.mx = s[i];
            if (s[i] < r.mn) r.mn = s[i];
        end
        first  = -1;
        r.ties = 0;
        foreach (s[i]) begin
            if (s[i] == r.mx) begin
                if (first < 0) first = i;
                r.ties++;
            end
        end
        r.idx  = sat(first);
        r.ties = sat(r.ties);
        r.cnt  = sat(s.size());
        return r;
    endfunction

    // Compare process: sampled on the falling edge, when inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_q.delete();
        end else begin
            check("out_valid", int'(bus.out_valid), int'(exp_q.size() > 0));
            check("in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && exp_q.size() > 0) begin
                check("m_max",  int'(bus.out_max),      exp_q[0].mx);
                check("m_min",  int'(bus.out_min),      exp_q[0].mn);
                check("m_idx",  int'(bus.out_max_idx),  exp_q[0].idx);
                check("m_ties", int'(bus.out_max_ties), exp_q[0].ties);
                check("m_cnt",  int'(bus.out_cnt),      exp_q[0].cnt);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    n_popped++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                cur_q.push_back(int'(bus.in_data));
                if (bus.in_last) begin
                    exp_q.push_back(model(cur_q));
                    cur_q.delete();
                end
            end
        end
    end

    // Random consumer backpressure.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Present one sample and hold it until the cycle it is accepted.
    task automatic send(input int d, input bit last);
        int tries;
        bit ok;
        tries = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(d);
        bus.in_last  = last;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 200);
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_rec(input string tag, input int mx, input int mn,
                             input int idx, input int ties, input int cnt);
        check({tag, "_valid"}, int'(bus.out_valid),    1);
        check({tag, "_max"},   int'(bus.out_max),      mx);
        check({tag, "_min"},   int'(bus.out_min),      mn);
        check({tag, "_idx"},   int'(bus.out_max_idx),  idx);
        check({tag, "_ties"},  int'(bus.out_max_ties), ties);
        check({tag, "_cnt"},   int'(bus.out_cnt),      cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap;
        int len;
        int mode;
        int d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_valid", int'(bus.out_valid),    0);
        check("rst_max",   int'(bus.out_max),      0);
        check("rst_min",   int'(bus.out_min),      0);
        check("rst_idx",   int'(bus.out_max_idx),  0);
        check("rst_ties",  int'(bus.out_max_ties), 0);
        check("rst_cnt",   int'(bus.out_cnt),      0);
        check("rst_ready", int'(bus.in_ready),     1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame
        send(5, 0); send(9, 0); send(3, 0); send(9, 0); send(7, 1);
        idle();
        check_rec("basic", 9, 3, 1, 2, 5);
        @(posedge clk); #1;
        check("basic_one_cycle", int'(bus.out_valid), 0);

        // Single-sample frame, then a two-sample frame right behind it
        send(16'hFFFF, 1);
        idle();
        check_rec("single", 65535, 65535, 0, 1, 1);
        send(0, 0); send(1, 1);
        idle();
        check_rec("two", 1, 0, 1, 1, 2);
        @(posedge clk); #1;

        // Backpressure: record A held, frame B's first sample held off
        bus.out_ready = 1'b0;
        send(4, 0); send(2, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd8;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", int'(bus.in_ready), 0);
            check_rec("held", 4, 2, 0, 1, 2);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(bus.in_ready), 1);
        send(8, 0);
        check("a_consumed", int'(bus.out_valid), 0);
        send(5, 1);
        idle();
        check_rec("frameB", 8, 5, 0, 1, 2);
        @(posedge clk); #1;

        // Saturation
        for (int i = 0; i < 300; i++) send(16'h0042, i == 299);
        idle();
        check_rec("sat", 66, 66, 0, 255, 255);
        @(posedge clk); #1;

        // Reset with a pending record
        bus.out_ready = 1'b0;
        send(7, 1);
        idle();
        check_rec("pend", 7, 7, 0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pend_valid", int'(bus.out_valid), 0);
        check("rst_pend_ready", int'(bus.in_ready),  1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Reset mid-frame
        send(10, 0); send(20, 0); send(30, 0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(1, 0); send(2, 1);
        idle();
        check_rec("after_rst", 2, 1, 1, 1, 2);
        @(posedge clk); #1;

        // Random frames with input gaps and consumer backpressure
        snap = n_popped;
        rand_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            len  = $urandom_range(1, 40);
            mode = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                d = mode ? $urandom_range(0, 7) : $urandom_range(0, 65535);
                send(d, i == len - 1);
            end
        end
        idle();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drained_queue", exp_q.size(), 0);
        check("drained_valid", int'(bus.out_valid), 0);
        check("random_records", n_popped - snap, 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_extrema_tracker.md
# frame_extrema_tracker

Streaming consumer for the 16-bit unsigned magnitude compare (lt/eq/gt) stage. It accepts a framed stream of unsigned samples over a valid/ready handshake and compares each sample against the running maximum and minimum. At the end of each frame it emits one result record: max, min, index of the first max, number of samples equal to the max, and sample count. It sits directly downstream of the operand compare path in the power-aware synthesis training set.

## Interface
- W, 16, sample width in bits (unsigned)
- CW, 8, width of count/index fields; saturating
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- in_data  in  W  sample, unsigned
- in_last  in  1  sample is the final one of its frame
- out_valid  out  1  result record valid
- out_ready  in  1  consumer accepts record
- out_max  out  W  frame maximum
- out_min  out  W  frame minimum
- out_max_idx  out  CW  zero-based index of the first occurrence of the maximum
- out_max_ties  out  CW  count of samples equal to the final maximum
- out_cnt  out  CW  samples in the frame

## Operation
- **Reset and clock:** asynchronous, active-low reset; single clock domain.
- **Accept:** a sample is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, which is combinational from registered out_valid.
- **State machine (accumulator):** two states.
  - FIRST: no frame open.
  - ACCUM: frame open.
- **Accept in FIRST:**
  - max = min = in_data; max_idx = 0; ties = 1; cnt = 1.
  - Go to ACCUM, unless in_last is set.
- **Accept in ACCUM:** compare in_data against max and min.
  - gt(max): max = in_data, max_idx = cnt, ties = 1.
  - eq(max): ties += 1.
  - lt(min): min = in_data.
  - cnt += 1.
  - All updates use pre-update register values in the same cycle.
- **Ties rule:** strict greater-than replaces the max, so max_idx always points at the first occurrence.
- **Saturation:** cnt, ties and max_idx saturate at 2^CW-1; they never wrap.
- **Last sample:** on an accepted sample with in_last, the updated accumulator values (including that sample) are loaded into the output registers. out_valid is set and the accumulator returns to FIRST.
- **Single-sample frame:** a frame of one sample (FIRST with in_last) yields max = min = in_data, idx 0, ties 1, cnt 1.
- **Output handshake:** out_valid stays high and out_* stay stable until out_valid && out_ready.
- **Back-to-back frames:** a new frame's samples may be accepted in the same cycle that the pending record is consumed.
- **Backpressure:** while out_valid && !out_ready, in_ready = 0 and the accumulator holds.
- **Reset mid-frame:** the open frame is discarded and the accumulator returns to FIRST.
- **Reset with a pending record:** any pending record is dropped.

## Timing
- **Reset values:** out_valid = 0, all out_* data = 0; accumulator registers 0; state FIRST. in_ready reads 1 while out_valid = 0.
- **Latency:** out_valid rises on the clock edge that accepts the in_last sample, so the record is visible the cycle after that sample is presented.
- **Throughput:** one sample per cycle; zero bubble between frames when out_ready is held high.
- **Out_valid with consumption:** if a last sample is accepted in the same cycle the previous record is consumed, out_valid stays 1 and out_* load the new record.
- **Stall:** in_valid low mid-frame leaves all state unchanged; there is no timeout.

## Structure
- Shared package `extrema_pkg` holds:
  - the state enum (FIRST, ACCUM);
  - the result record struct (max, min, max_idx, max_ties, cnt), parameterised through W/CW localparams;
  - a saturating-increment function.
- One sub-module, `mag_cmp16`: combinational unsigned compare of two W-bit operands, producing lt/eq/gt.
  - Instantiated twice: sample vs max, and sample vs min.
  - Exactly one of its outputs is high for any operand pair.
- Top level holds the accumulator registers, the output register bank and the handshake logic.

## Test plan
- **Basic frame:** frame 5, 9, 3, 9, 7(last), out_ready = 1 → one record: max 9, min 3, max_idx 1, max_ties 2, cnt 5; out_valid high for exactly 1 cycle.
- **Single-sample frame:** single sample 0xFFFF with in_last → max = min = 0xFFFF, idx 0, ties 1, cnt 1; the next frame 0x0000, 0x0001(last) gives max 1, min 0, idx 1, ties 1, cnt 2.
- **Backpressure and back-to-back:**
  - Frame A (4, 2 last) followed immediately by frame B (8 ...) with out_ready = 0 for 5 cycles → in_ready = 0 throughout; record A is stable; frame B's first sample is held off.
  - Raise out_ready → A consumed and B's first sample accepted in the same cycle.
- **Saturation (CW = 8):** 300 samples all equal to 0x0042 → cnt 255, ties 255, max_idx 0, max = min = 0x0042.
- **Reset mid-frame:** assert rst_n = 0 asynchronously mid-frame after 3 samples (10, 20, 30); release; then send frame 1, 2(last) → out_valid = 0 immediately on reset; record is max 2, min 1, cnt 2 with no residue from the aborted frame.
- **Random check:** random frames of lengths 1–40 with random in_valid/out_ready gaps → every record matches a reference model; no record is lost or duplicated.
